fuzzy_job_scheduler: RTL and testbench
======================================

# fuzzy_job_scheduler

Shares the single fuzzy inference engine between two operand requesters. Each requester presents an 8-bit operand pair with a valid/ready handshake; the block arbitrates round-robin, loads the winning pair onto the engine's operand lines, pulses start, waits for done with a timeout, and returns the result tagged with the requester ID. It sits between the bus-side operand loaders and the engine, and replaces ad-hoc direct operand loading.

## Interface
- TIMEOUT, 16: maximum WAIT cycles before abort; legal range 2..255.

- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  synchronous reset, active-low
- req0_valid  in  1  requester 0 has an operand pair
- req0_a, req0_b  in  8 each  requester 0 operands
- req0_ready  out  1  requester 0 pair accepted this cycle
- req1_valid, req1_a, req1_b, req1_ready  same as requester 0, for requester 1
- eng_start  out  1  one-cycle engine start pulse
- eng_s1, eng_s2  out  8 each  operands to the engine
- eng_done  in  1  engine result valid (single-cycle or held)
- eng_result  in  8  engine result
- rsp_valid  out  1  response available
- rsp_id  out  1  requester that owns the response
- rsp_data  out  8  result; 0x00 on error
- rsp_err  out  1  1 = zero operand or timeout
- rsp_ready  in  1  response consumer accepts
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any reqN_valid, grant exactly one. Acceptance = reqN_valid & reqN_ready, with reqN_ready high only in IDLE for the granted requester. Operands and ID are captured on acceptance.
- Arbitration: round-robin on a last-grant pointer. If both requesters are valid, the one not granted last wins. If only one is valid, it wins. The pointer resets so that requester 0 wins the first contention. The pointer updates only on acceptance.
- Zero-operand rule: if a captured operand is 0x00 (either one), the engine is not started. Next state is RESP with rsp_err=1 and rsp_data=0x00.
- Otherwise IDLE → ISSUE → WAIT.
- ISSUE: eng_start=1 for exactly this cycle.
- eng_s1/eng_s2 drive the captured operands from ISSUE through the last WAIT cycle. Outside that window they are 0x00.
- WAIT: an 8-bit counter starts at 0 on entry and increments each WAIT cycle.
  - If eng_done=1, capture eng_result, set rsp_err=0, go to RESP.
  - Else if counter == TIMEOUT-1, set rsp_err=1 and rsp_data=0x00, go to RESP.
  - If eng_done arrives on the timeout cycle, done wins and there is no error.
- eng_done is ignored in IDLE, ISSUE and RESP. A late done after a timeout is discarded.
- RESP: rsp_valid=1, with rsp_id/rsp_data/rsp_err held stable until rsp_valid & rsp_ready. On that handshake, go to IDLE. The response registers then clear to 0.
- Requests arriving while not IDLE are held off (ready low). Requesters must hold valid and operands stable until accepted.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, pointer favours requester 0, counter 0. Every output is 0: req0_ready, req1_ready, eng_start, eng_s1, eng_s2, rsp_valid, rsp_id, rsp_data, rsp_err, busy.
- Reset mid-operation aborts the job without a response and forces the outputs above to 0 on the next edge.
- reqN_ready is combinational from state, pointer and valids, in the IDLE cycle only.
- Acceptance at edge T:
  - eng_start high in cycle T+1 (ISSUE).
  - WAIT begins at T+2.
  - eng_done sampled high in cycle W gives rsp_valid high from W+1.
  - Minimum accept-to-response latency is 3 cycles (done in the first WAIT cycle).
- Timeout: with no done, rsp_valid rises at T+2+TIMEOUT.
- Zero-operand reject: rsp_valid rises at T+1.
- Back-to-back: the handshake at edge R returns to IDLE; the next acceptance happens no earlier than cycle R+1. Throughput is at most one job per 4 cycles.
- busy is registered from state and is high from T+1 until the cycle after the RESP handshake.

## Test plan
- Single job: req0 a=0x3C, b=0x51; engine returns 0xA7 two cycles after start. Expect eng_start exactly one cycle and eng_s1/s2=0x3C/0x51 in ISSUE..WAIT. Response id=0, data=0xA7, err=0 at accept+4.
- Contention: both valid continuously, 4 jobs, engine always responds. Expect grant order 0,1,0,1, each rsp_id matching, and no ready asserted outside IDLE.
- Zero operand: req1 a=0x00, b=0x22. Expect no eng_start, rsp_valid at accept+1, id=1, err=1, data=0x00. The next contention favours requester 0.
- Timeout: TIMEOUT=16, engine never responds. Expect rsp err=1, data=0x00 at accept+18. A late eng_done afterwards produces no response and no state change.
- Done on the timeout cycle: done asserted on WAIT count 15 with result 0x11. Expect err=0, data=0x11.
- Backpressure and reset: hold rsp_ready=0 for 10 cycles and check the response stays stable. Then drop rst_n in WAIT on another job and check all outputs are 0 next cycle, with no response afterwards.

Source files
------------

// File: rtl/fuzzy_job_scheduler.sv
// Round-robin front end for the shared fuzzy inference engine: accepts operand
// pairs from two requesters, runs one engine job at a time and returns a tagged result.
module fuzzy_job_scheduler #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       req1_ready,
  output logic       eng_start,
  output logic [7:0] eng_s1,
  output logic [7:0] eng_s2,
  input  logic       eng_done,
  input  logic [7:0] eng_result,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  input  logic       rsp_ready,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       last_grant;
  logic       grant;
  logic       accept;
  logic       zero_op;
  logic [7:0] sel_a, sel_b;
  logic [7:0] op_a, op_b;
  logic       job_id;
  logic [7:0] wait_cnt;
  logic       wait_end;

  // Requester 1 wins only when it is alone or requester 0 was granted last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid)
      grant = ~last_grant;
    else if (req1_valid)
      grant = 1'b1;
    accept   = (state == IDLE) && (req0_valid || req1_valid);
    sel_a    = grant ? req1_a : req0_a;
    sel_b    = grant ? req1_b : req0_b;
    zero_op  = (sel_a == 8'h00) || (sel_b == 8'h00);
    wait_end = eng_done || (wait_cnt == TO_LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = zero_op ? RESP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_end) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req0_ready = (state == IDLE) && req0_valid && !grant;
    req1_ready = (state == IDLE) && req1_valid && grant;
    eng_start  = (state == ISSUE);
    busy       = (state != IDLE);
    rsp_valid  = (state == RESP);
    eng_s1     = 8'h00;
    eng_s2     = 8'h00;
    if (state == ISSUE || state == WAIT) begin
      eng_s1 = op_a;
      eng_s2 = op_b;
    end
  end

  // Control: arbitration pointer, wait counter and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      wait_cnt   <= 8'd0;
      rsp_id     <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_err    <= 1'b0;
    end else begin
      if (accept)
        last_grant <= grant;
      wait_cnt <= (state == WAIT) ? wait_cnt + 8'd1 : 8'd0;
      case (state)
        IDLE: begin
          if (accept && zero_op) begin
            rsp_id   <= grant;
            rsp_data <= 8'h00;
            rsp_err  <= 1'b1;
          end
        end
        WAIT: begin
          if (eng_done) begin
            rsp_id   <= job_id;
            rsp_data <= eng_result;
            rsp_err  <= 1'b0;
          end else if (wait_cnt == TO_LAST) begin
            rsp_id   <= job_id;
            rsp_data <= 8'h00;
            rsp_err  <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_id   <= 1'b0;
            rsp_data <= 8'h00;
            rsp_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand capture; these are only visible through the state-gated engine lines
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a   <= sel_a;
      op_b   <= sel_b;
      job_id <= grant;
    end
  end

endmodule

// File: tb/tb_fuzzy_job_scheduler.sv
// Directed bench for fuzzy_job_scheduler with hand-computed expected values.
module tb_fuzzy_job_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       eng_start;
  logic [7:0] eng_s1, eng_s2;
  logic       eng_done;
  logic [7:0] eng_result;
  logic       rsp_valid, rsp_id, rsp_err, rsp_ready, busy;
  logic [7:0] rsp_data;

  int checks   = 0;
  int failures = 0;

  fuzzy_job_scheduler #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .eng_start(eng_start), .eng_s1(eng_s1), .eng_s2(eng_s2),
    .eng_done(eng_done), .eng_result(eng_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_r0"},   req0_ready, 0);
    chk({tag, "_r1"},   req1_ready, 0);
    chk({tag, "_st"},   eng_start, 0);
    chk({tag, "_s1"},   eng_s1, 0);
    chk({tag, "_s2"},   eng_s2, 0);
    chk({tag, "_rv"},   rsp_valid, 0);
    chk({tag, "_id"},   rsp_id, 0);
    chk({tag, "_dat"},  rsp_data, 0);
    chk({tag, "_err"},  rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int exp_id;
    rst_n = 1'b0; req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    eng_done = 0; eng_result = 0; rsp_ready = 0;
    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Contention: both valid continuously, expect grants 0,1,0,1
    req0_valid = 1; req0_a = 8'h11; req0_b = 8'h12;
    req1_valid = 1; req1_a = 8'h21; req1_b = 8'h22;
    rsp_ready = 1;
    for (int j = 0; j < 4; j++) begin
      exp_id = j % 2;
      #1;
      chk("rr_ready0", req0_ready, (exp_id == 0));
      chk("rr_ready1", req1_ready, (exp_id == 1));
      tick();
      chk("rr_start", eng_start, 1);
      chk("rr_s1", eng_s1, exp_id ? 8'h21 : 8'h11);
      chk("rr_s2", eng_s2, exp_id ? 8'h22 : 8'h12);
      chk("rr_issue_rdy", {req0_ready, req1_ready}, 0);
      tick();
      eng_done = 1; eng_result = 8'h40 + 8'(j);
      chk("rr_start_off", eng_start, 0);
      chk("rr_wait_rdy", {req0_ready, req1_ready}, 0);
      tick();
      eng_done = 0;
      chk("rr_rv", rsp_valid, 1);
      chk("rr_id", rsp_id, exp_id);
      chk("rr_data", rsp_data, 8'h40 + j);
      chk("rr_err", rsp_err, 0);
      chk("rr_resp_rdy", {req0_ready, req1_ready}, 0);
      tick();
      chk("rr_idle_rv", rsp_valid, 0);
    end
    req0_valid = 0; req1_valid = 0;

    // Single job: 0x3C/0x51, engine answers 0xA7 two cycles after start
    req0_valid = 1; req0_a = 8'h3C; req0_b = 8'h51;
    #1;
    chk("sj_ready0", req0_ready, 1);
    chk("sj_ready1", req1_ready, 0);
    tick();
    req0_valid = 0;
    chk("sj_start", eng_start, 1);
    chk("sj_s1_issue", eng_s1, 8'h3C);
    chk("sj_s2_issue", eng_s2, 8'h51);
    chk("sj_busy", busy, 1);
    tick();
    chk("sj_start_once", eng_start, 0);
    chk("sj_s1_wait", eng_s1, 8'h3C);
    chk("sj_s2_wait", eng_s2, 8'h51);
    tick();
    eng_done = 1; eng_result = 8'hA7;
    chk("sj_rv_early", rsp_valid, 0);
    chk("sj_s1_wait1", eng_s1, 8'h3C);
    tick();
    eng_done = 0;
    chk("sj_rv", rsp_valid, 1);
    chk("sj_id", rsp_id, 0);
    chk("sj_data", rsp_data, 8'hA7);
    chk("sj_err", rsp_err, 0);
    chk("sj_s1_resp", eng_s1, 0);
    tick();
    chk("sj_rv_clr", rsp_valid, 0);
    chk("sj_data_clr", rsp_data, 0);
    chk("sj_busy_clr", busy, 0);

    // Zero operand on requester 1
    req1_valid = 1; req1_a = 8'h00; req1_b = 8'h22;
    #1;
    chk("zo_ready1", req1_ready, 1);
    tick();
    req1_valid = 0;
    chk("zo_rv", rsp_valid, 1);
    chk("zo_start", eng_start, 0);
    chk("zo_id", rsp_id, 1);
    chk("zo_err", rsp_err, 1);
    chk("zo_data", rsp_data, 0);
    chk("zo_s1", eng_s1, 0);
    tick();
    chk("zo_rv_clr", rsp_valid, 0);
    chk("zo_busy", busy, 0);
    req0_valid = 1; req1_valid = 1; req0_a = 8'h01; req0_b = 8'h01;
    #1;
    chk("zo_next_rdy0", req0_ready, 1);
    chk("zo_next_rdy1", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;

    // Timeout: engine never answers
    tick();
    req0_valid = 1; req0_a = 8'h05; req0_b = 8'h06;
    tick();
    req0_valid = 0;
    for (int k = 1; k <= 17; k++) begin
      chk("to_rv_low", rsp_valid, 0);
      if (k == 17) chk("to_s1_last", eng_s1, 8'h05);
      tick();
    end
    chk("to_rv", rsp_valid, 1);
    chk("to_err", rsp_err, 1);
    chk("to_data", rsp_data, 0);
    chk("to_id", rsp_id, 0);
    chk("to_s1_off", eng_s1, 0);
    tick();
    eng_done = 1; eng_result = 8'h99;
    tick();
    eng_done = 0;
    chk("late_rv", rsp_valid, 0);
    chk("late_busy", busy, 0);
    chk("late_start", eng_start, 0);
    tick();
    chk("late_rv2", rsp_valid, 0);
    chk("late_data", rsp_data, 0);

    // Done on the timeout cycle wins
    req1_valid = 1; req1_a = 8'h0A; req1_b = 8'h0B;
    tick();
    req1_valid = 0;
    for (int k = 0; k < 16; k++) tick();
    chk("dt_rv_low", rsp_valid, 0);
    eng_done = 1; eng_result = 8'h11;
    tick();
    eng_done = 0;
    chk("dt_rv", rsp_valid, 1);
    chk("dt_err", rsp_err, 0);
    chk("dt_data", rsp_data, 8'h11);
    chk("dt_id", rsp_id, 1);
    tick();

    // Backpressure: response stays stable while rsp_ready is low
    rsp_ready = 0;
    req1_valid = 1; req1_a = 8'h07; req1_b = 8'h08;
    tick();
    req1_valid = 0;
    tick();
    eng_done = 1; eng_result = 8'h5A;
    tick();
    eng_done = 0;
    req0_valid = 1; req0_a = 8'h09; req0_b = 8'h09;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("bp_rv", rsp_valid, 1);
      chk("bp_id", rsp_id, 1);
      chk("bp_data", rsp_data, 8'h5A);
      chk("bp_err", rsp_err, 0);
      chk("bp_rdy0", req0_ready, 0);
      tick();
    end
    req0_valid = 0;
    rsp_ready = 1;
    tick();
    chk("bp_rv_clr", rsp_valid, 0);

    // Reset while waiting on the engine
    req0_valid = 1; req0_a = 8'h01; req0_b = 8'h02;
    tick();
    req0_valid = 0;
    tick();
    chk("rw_busy", busy, 1);
    chk("rw_s1", eng_s1, 8'h01);
    rst_n = 0;
    tick();
    chk_all_zero("rw");
    rst_n = 1;
    eng_done = 1; eng_result = 8'h77;
    tick();
    eng_done = 0;
    for (int k = 0; k < 3; k++) begin
      chk("rw_no_rsp", rsp_valid, 0);
      chk("rw_idle", busy, 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
